// File: rtl/revo_word_generator_pkg.sv
// Shared constants, FSM encoding and input-sanitising helpers for the revolution-marker word generator.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package revo_word_generator_pkg;

    localparam int BITS_PER_BUCKET      = 2;
    localparam int BUCKETS_PER_WORD     = 4;
    localparam int WORD_BITS            = BITS_PER_BUCKET * BUCKETS_PER_WORD;
    localparam int WORD_IDX_BITS        = 11;
    localparam int WIDTH_BITS           = 5;
    localparam int DEF_BUCKETS_PER_REVO = 5120;

    typedef enum logic [1:0] {
        ST_STOPPED  = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_DRAINING = 2'd2
    } revo_state_e;

    // Width 0 means a single bucket; anything above max_w saturates.
    function automatic logic [WIDTH_BITS-1:0] clamp_width(input logic [WIDTH_BITS-1:0] w,
                                                          input int                   max_w);
        logic [WIDTH_BITS-1:0] res;
        res = w;
        if (w == '0) begin
            res = WIDTH_BITS'(1);
        end else if (int'(w) > max_w) begin
            res = WIDTH_BITS'(max_w);
        end
        return res;
    endfunction

endpackage

// File: rtl/revo_bucket_mask.sv
// Builds the 8-bit marker word for one word index from the latched offset/width (4 parallel compares).
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle.
//
// Ports:
//   word_idx  in   word counter value w
//   offset    in   first marked bucket, already reduced below BUCKETS_PER_REVO
//   width     in   marker width in buckets, already clamped to 1..MAX_WIDTH
//   mask      out  bucket k drives bits {7-2k, 6-2k}
module revo_bucket_mask
    import revo_word_generator_pkg::*;
#(
    parameter int BUCKETS_PER_REVO = DEF_BUCKETS_PER_REVO,
    parameter int OFFSET_BITS      = 13
) (
    input  logic [WORD_IDX_BITS-1:0] word_idx,
    input  logic [OFFSET_BITS-1:0]   offset,
    input  logic [WIDTH_BITS-1:0]    width,
    output logic [WORD_BITS-1:0]     mask
);

    // One extra bit so p + N - offset never overflows before the single conditional subtract.
    localparam logic [OFFSET_BITS:0] N_EXT = (OFFSET_BITS+1)'(BUCKETS_PER_REVO);

    for (genvar k = 0; k < BUCKETS_PER_WORD; k++) begin : g_bucket
        logic [OFFSET_BITS:0] pos;
        logic [OFFSET_BITS:0] diff_raw;
        logic [OFFSET_BITS:0] diff;
        logic                 hit;

        // Bucket number p = 4*w + k.
        assign pos      = (OFFSET_BITS+1)'({word_idx, 2'(k)});
        assign diff_raw = pos + N_EXT - {1'b0, offset};
        assign diff     = (diff_raw >= N_EXT) ? (diff_raw - N_EXT) : diff_raw;
        assign hit      = (diff < (OFFSET_BITS+1)'(width));

        assign mask[WORD_BITS-1-BITS_PER_BUCKET*k -: BITS_PER_BUCKET] = {BITS_PER_BUCKET{hit}};
    end

endmodule

// File: rtl/revo_word_generator.sv
// Revolution-marker word source for the revo OSERDES lane: counts words around the ring, marks a bucket window.
// Latency: 1 cycle from counting word w to revo_word/revo/word_index for w on the outputs.
// Backpressure: none; one word every clock while running, OSERDES consumes unconditionally.
//
// Ports:
//   clock, reset   word clock; synchronous active-high reset
//   enable         run request (level); dropping it finishes the current revolution first
//   offset, width  marker placement, latched at start and at every revolution wrap
//   revo_word      8-bit word, bit 7 serialised first
//   revo           strobe with the word holding bucket 'offset'
//   word_index     index of the word currently on revo_word
//   running        FSM not STOPPED
// Optional build macro REVO_WORD_GENERATOR_EXT_SYNC_EN adds ext_sync (phase lock to an
// external revolution marker) and sync_slip (ext_sync seen anywhere but the last word).
module revo_word_generator
    import revo_word_generator_pkg::*;
#(
    parameter int BUCKETS_PER_REVO = DEF_BUCKETS_PER_REVO,
    parameter int MAX_WIDTH        = 16,
    parameter int OFFSET_BITS      = 13
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [OFFSET_BITS-1:0]   offset,
    input  logic [WIDTH_BITS-1:0]    width,
`ifdef REVO_WORD_GENERATOR_EXT_SYNC_EN
    input  logic                     ext_sync,
    output logic                     sync_slip,
`endif
    output logic [WORD_BITS-1:0]     revo_word,
    output logic                     revo,
    output logic [WORD_IDX_BITS-1:0] word_index,
    output logic                     running
);

    localparam int                         WORDS_PER_REVO = BUCKETS_PER_REVO / BUCKETS_PER_WORD;
    localparam logic [WORD_IDX_BITS-1:0]   LAST_WORD      = WORD_IDX_BITS'(WORDS_PER_REVO - 1);
    localparam logic [OFFSET_BITS-1:0]     N_OFF          = OFFSET_BITS'(BUCKETS_PER_REVO);

    revo_state_e               state_q, state_d;
    logic [WORD_IDX_BITS-1:0]  w_q, w_d;
    logic [OFFSET_BITS-1:0]    off_q, off_d;
    logic [WIDTH_BITS-1:0]     wid_q, wid_d;
    logic [WORD_BITS-1:0]      revo_word_q, revo_word_d;
    logic                      revo_q, revo_d;
    logic [WORD_IDX_BITS-1:0]  word_index_q, word_index_d;
    logic                      slip_q, slip_d;

    logic [WORD_BITS-1:0]      mask_w;
    logic                      active;
    logic                      wrap;
    logic                      sync;
    logic                      load;

    revo_bucket_mask #(
        .BUCKETS_PER_REVO (BUCKETS_PER_REVO),
        .OFFSET_BITS      (OFFSET_BITS)
    ) u_mask (
        .word_idx (w_q),
        .offset   (off_q),
        .width    (wid_q),
        .mask     (mask_w)
    );

    always_comb begin
        state_d      = state_q;
        w_d          = w_q;
        off_d        = off_q;
        wid_d        = wid_q;
        revo_word_d  = '0;
        revo_d       = 1'b0;
        word_index_d = '0;
        slip_d       = 1'b0;

        active = (state_q != ST_STOPPED);
        wrap   = active && (w_q == LAST_WORD);
`ifdef REVO_WORD_GENERATOR_EXT_SYNC_EN
        sync   = active && ext_sync;
`else
        sync   = 1'b0;
`endif

        case (state_q)
            ST_STOPPED: begin
                w_d = '0;
                if (enable) begin
                    state_d = ST_RUNNING;
                end
            end
            ST_RUNNING: begin
                // Dropping enable on the last word has already completed the revolution.
                if (!enable) begin
                    state_d = wrap ? ST_STOPPED : ST_DRAINING;
                end
            end
            ST_DRAINING: begin
                if (enable) begin
                    state_d = ST_RUNNING;
                end else if (wrap) begin
                    state_d = ST_STOPPED;
                end
            end
            default: begin
                state_d = ST_STOPPED;
            end
        endcase

        if (active) begin
            revo_word_d  = mask_w;
            // Word holding the offset bucket is offset / BUCKETS_PER_WORD.
            revo_d       = (OFFSET_BITS'(w_q) == (off_q >> 2));
            word_index_d = w_q;
            w_d          = (wrap || sync) ? '0 : (w_q + 1'b1);
            slip_d       = sync && !wrap;
        end

        // New placement only ever takes effect from word 0 of a revolution.
        load = ((state_q == ST_STOPPED) && enable) || wrap || sync;
        if (load) begin
            off_d = (offset >= N_OFF) ? (offset - N_OFF) : offset;
            wid_d = clamp_width(width, MAX_WIDTH);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_STOPPED;
            w_q          <= '0;
            off_q        <= '0;
            wid_q        <= WIDTH_BITS'(1);
            revo_word_q  <= '0;
            revo_q       <= 1'b0;
            word_index_q <= '0;
            slip_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            w_q          <= w_d;
            off_q        <= off_d;
            wid_q        <= wid_d;
            revo_word_q  <= revo_word_d;
            revo_q       <= revo_d;
            word_index_q <= word_index_d;
            slip_q       <= slip_d;
        end
    end

    assign revo_word  = revo_word_q;
    assign revo       = revo_q;
    assign word_index = word_index_q;
    assign running    = (state_q != ST_STOPPED);

`ifdef REVO_WORD_GENERATOR_EXT_SYNC_EN
    assign sync_slip  = slip_q;
`else
    logic unused_slip;
    assign unused_slip = slip_q;
`endif

endmodule

// File: tb/tb_revo_word_generator.sv
// Directed self-checking bench for revo_word_generator (default build).
// Latency: n/a.
// Backpressure: n/a.
module tb_revo_word_generator;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [12:0] offset;
    logic [4:0]  width;
    logic [7:0]  revo_word;
    logic        revo;
    logic [10:0] word_index;
    logic        running;
`ifdef REVO_WORD_GENERATOR_EXT_SYNC_EN
    logic        ext_sync;
    logic        sync_slip;
`endif

    int vectors;
    int miscompares;

    revo_word_generator dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .offset     (offset),
        .width      (width),
`ifdef REVO_WORD_GENERATOR_EXT_SYNC_EN
        .ext_sync   (ext_sync),
        .sync_slip  (sync_slip),
`endif
        .revo_word  (revo_word),
        .revo       (revo),
        .word_index (word_index),
        .running    (running)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance until the given index is on the outputs; an expired budget shows up as a miscompare.
    task automatic goto_idx(input int idx);
        int n;
        n = 0;
        while (word_index !== 11'(idx) && n < 3000) begin
            tick();
            n++;
        end
        check($sformatf("goto_%0d", idx), 32'(word_index), 32'(idx));
    endtask

    task automatic check_word(input string tag, input logic [7:0] exp_word, input logic exp_revo);
        check({tag, "_word"}, 32'(revo_word), 32'(exp_word));
        check({tag, "_revo"}, 32'(revo), 32'(exp_revo));
    endtask

    initial begin
        int revo_cnt;
        int nz_cnt;
        vectors     = 0;
        miscompares = 0;
        reset  = 1'b1;
        enable = 1'b0;
        offset = 13'd0;
        width  = 5'd2;
`ifdef REVO_WORD_GENERATOR_EXT_SYNC_EN
        ext_sync = 1'b0;
`endif
        tick();
        tick();
        check_word("rst", 8'h00, 1'b0);
        check("rst_idx", 32'(word_index), 32'd0);
        check("rst_running", 32'(running), 32'd0);

        reset = 1'b0;
        tick();
        check("idle_running", 32'(running), 32'd0);

        // Revolution 1: offset 0, width 2.
        enable = 1'b1;
        tick();
        check("start_running", 32'(running), 32'd1);
        check("start_word", 32'(revo_word), 32'd0);
        tick();
        check_word("r1_w0", 8'hF0, 1'b1);
        check("r1_w0_idx", 32'(word_index), 32'd0);
        revo_cnt = 0;
        nz_cnt   = 0;
        for (int i = 0; i < 1279; i++) begin
            tick();
            if (revo === 1'b1) revo_cnt++;
            if (revo_word !== 8'h00) nz_cnt++;
        end
        check("r1_tail_idx", 32'(word_index), 32'd1279);
        check("r1_tail_revo_cnt", 32'(revo_cnt), 32'd0);
        check("r1_tail_nz_cnt", 32'(nz_cnt), 32'd0);

        // Change placement now; revolution 2 already latched offset 0.
        offset = 13'd5119;
        width  = 5'd2;
        tick();
        check_word("r2_w0_period", 8'hF0, 1'b1);
        goto_idx(1279);
        check_word("r2_w1279_old", 8'h00, 1'b0);
        tick();
        check_word("r3_w0_span", 8'hC0, 1'b0);
        goto_idx(1279);
        check_word("r3_w1279", 8'h03, 1'b1);

        // Offset 6, width 5 latched at the end of revolution 4.
        offset = 13'd6;
        width  = 5'd5;
        tick();
        check_word("r4_w0_old", 8'hC0, 1'b0);
        goto_idx(1279);
        check_word("r4_w1279_old", 8'h03, 1'b1);
        tick();
        check_word("r5_w0", 8'h00, 1'b0);
        tick();
        check_word("r5_w1", 8'h0F, 1'b1);
        tick();
        check_word("r5_w2", 8'hFC, 1'b0);

        // Mid-revolution change: no effect until revolution 6.
        offset = 13'd100;
        width  = 5'd3;
        goto_idx(25);
        check_word("r5_w25_old", 8'h00, 1'b0);
        goto_idx(1);
        check_word("r6_w1", 8'h00, 1'b0);
        goto_idx(25);
        check_word("r6_w25", 8'hFC, 1'b1);

        // Out of range: 8191 -> 3071, width 31 -> 16 (buckets 3071..3086).
        offset = 13'd8191;
        width  = 5'd31;
        goto_idx(0);
        check_word("r7_w0", 8'h00, 1'b0);

        // Drop enable mid-revolution; the revolution still completes.
        goto_idx(300);
        enable = 1'b0;
        goto_idx(766);
        check_word("drain_w766", 8'h00, 1'b0);
        check("drain_running", 32'(running), 32'd1);
        tick();
        check_word("drain_w767", 8'h03, 1'b1);
        tick();
        check_word("drain_w768", 8'hFF, 1'b0);
        goto_idx(771);
        check_word("drain_w771", 8'hFC, 1'b0);
        tick();
        check_word("drain_w772", 8'h00, 1'b0);
        goto_idx(1279);
        tick();
        check_word("stopped", 8'h00, 1'b0);
        check("stopped_idx", 32'(word_index), 32'd0);
        check("stopped_running", 32'(running), 32'd0);
        for (int i = 0; i < 5; i++) tick();
        check("stopped_hold_idx", 32'(word_index), 32'd0);
        check("stopped_hold_running", 32'(running), 32'd0);

        // Restart, drop enable and raise it again before the wrap: keeps running.
        offset = 13'd0;
        width  = 5'd2;
        enable = 1'b1;
        tick();
        tick();
        check_word("restart_w0", 8'hF0, 1'b1);
        goto_idx(100);
        enable = 1'b0;
        goto_idx(200);
        check("redrain_running", 32'(running), 32'd1);
        enable = 1'b1;
        goto_idx(1279);
        tick();
        check_word("resume_w0", 8'hF0, 1'b1);
        check("resume_running", 32'(running), 32'd1);

        // Synchronous reset mid-revolution.
        goto_idx(700);
        reset = 1'b1;
        tick();
        check_word("rst700", 8'h00, 1'b0);
        check("rst700_idx", 32'(word_index), 32'd0);
        check("rst700_running", 32'(running), 32'd0);
        reset = 1'b0;
        tick();
        check("rst_rel_running", 32'(running), 32'd1);
        check("rst_rel_word", 32'(revo_word), 32'd0);
        tick();
        check_word("rst_rel_w0", 8'hF0, 1'b1);
        check("rst_rel_w0_idx", 32'(word_index), 32'd0);
        tick();
        check("rst_rel_w1_idx", 32'(word_index), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
